// File: rtl/riscv_mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter.
//   - Port-ID constants: ARB_PORT_IMEM (instruction port), ARB_PORT_DMEM (data port).
//   - Request/response message widths, built from the VC_MEM_* size macros.
// The VC_MEM_* macros are defined here only if the surrounding codebase has
// not already provided them.
// Request message layout:  {type[1], addr[32], len[2], data[32]}  = 67 bits.
// Response message layout: {type[1], len[2], data[32]}            = 35 bits.

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(addr_sz_, data_sz_) (1 + (addr_sz_) + 2 + (data_sz_))
`endif

`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(data_sz_) (1 + 2 + (data_sz_))
`endif

package riscv_mem_port_arbiter_pkg;

  // Requester IDs stored in the outstanding-request queue.
  localparam logic ARB_PORT_IMEM = 1'b0;
  localparam logic ARB_PORT_DMEM = 1'b1;

  localparam int ARB_REQ_SZ  = `VC_MEM_REQ_MSG_SZ(32, 32);
  localparam int ARB_RESP_SZ = `VC_MEM_RESP_MSG_SZ(32);

endpackage

// File: rtl/riscv_mem_port_arbiter_if.sv
// Bus bundle for riscv_mem_port_arbiter.
//   - req0/resp0 : instruction port (val/rdy request, val-only response)
//   - req1/resp1 : data port
//   - memreq     : arbitrated val/rdy request to the single-port memory
//   - memresp    : memory response (val-only, always consumed)
// Modports:
//   slave  : the arbiter's view (receives requests, drives memory side)
//   master : the environment's view (core ports and memory model)

interface riscv_mem_port_arbiter_if
  import riscv_mem_port_arbiter_pkg::*;
#(
  parameter int p_req_sz  = ARB_REQ_SZ,
  parameter int p_resp_sz = ARB_RESP_SZ
);

  logic [p_req_sz-1:0]  req0_msg;
  logic                 req0_val;
  logic                 req0_rdy;
  logic [p_resp_sz-1:0] resp0_msg;
  logic                 resp0_val;

  logic [p_req_sz-1:0]  req1_msg;
  logic                 req1_val;
  logic                 req1_rdy;
  logic [p_resp_sz-1:0] resp1_msg;
  logic                 resp1_val;

  logic [p_req_sz-1:0]  memreq_msg;
  logic                 memreq_val;
  logic                 memreq_rdy;
  logic [p_resp_sz-1:0] memresp_msg;
  logic                 memresp_val;

  modport slave (
    input  req0_msg, req0_val,
    output req0_rdy, resp0_msg, resp0_val,
    input  req1_msg, req1_val,
    output req1_rdy, resp1_msg, resp1_val,
    output memreq_msg, memreq_val,
    input  memreq_rdy,
    input  memresp_msg, memresp_val
  );

  modport master (
    output req0_msg, req0_val,
    input  req0_rdy, resp0_msg, resp0_val,
    output req1_msg, req1_val,
    input  req1_rdy, resp1_msg, resp1_val,
    input  memreq_msg, memreq_val,
    output memreq_rdy,
    output memresp_msg, memresp_val
  );

endinterface

// File: rtl/riscv_mem_arbiter_idq.sv
// Circular in-order queue of 1-bit requester IDs for outstanding memory requests.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the queue)
//   push        : enqueue push_id at tail (caller guarantees !full)
//   push_id     : requester ID to enqueue
//   pop         : dequeue head (caller guarantees !empty)
//   head_id     : ID of the oldest outstanding request
//   full, empty : occupancy flags
// p_depth must be a power of two so the pointers wrap naturally.

module riscv_mem_arbiter_idq #(
  parameter int p_depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             ids [p_depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) ids[tail] <= push_id;
  end

  assign head_id = ids[head];
  assign full    = (count == CNT_W'(p_depth));
  assign empty   = (count == '0);

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// Shares one single-ported memory between the core's instruction port (0)
// and data port (1).
//   - Round-robin arbitration over the two val/rdy request channels, zero
//     added latency: the granted request is presented to memory in the same
//     cycle it is offered.
//   - Each accepted request pushes its requester ID into an in-order queue;
//     each memory response pops the queue and is steered to that requester.
//   - A response with no outstanding request is dropped and sets the sticky
//     err flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : riscv_mem_port_arbiter_if.slave (req0/resp0, req1/resp1,
//                memreq, memresp channels)
//   err        : sticky protocol error (response while nothing outstanding)
// Optional build macro RISCV_MEM_ARB_STATS_EN adds 32-bit event counters
// num_grant0, num_grant1, num_conflict, num_full_stall for hierarchical
// readout; functional behaviour is unaffected.

module riscv_mem_port_arbiter
  import riscv_mem_port_arbiter_pkg::*;
#(
  parameter int p_req_sz  = ARB_REQ_SZ,
  parameter int p_resp_sz = ARB_RESP_SZ,
  parameter int p_max_out = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  riscv_mem_port_arbiter_if.slave        bus,
  output logic                           err
);

  logic                 any_val;
  logic                 both_val;
  logic                 grant_id;
  logic                 prio;
  logic                 fire;
  logic                 q_full;
  logic                 q_empty;
  logic                 head_id;
  logic                 pop;
  logic [p_req_sz-1:0]  gnt_msg;
  logic [p_resp_sz-1:0] resp_msg;

  assign any_val  = bus.req0_val | bus.req1_val;
  assign both_val = bus.req0_val & bus.req1_val;

  // A lone requester always wins; on contention prio picks the winner.
  always_comb begin
    grant_id = ARB_PORT_IMEM;
    if (both_val)
      grant_id = prio;
    else if (bus.req1_val)
      grant_id = ARB_PORT_DMEM;
  end

  always_comb begin
    gnt_msg = '0;
    if (any_val)
      gnt_msg = (grant_id == ARB_PORT_DMEM) ? bus.req1_msg : bus.req0_msg;
  end

  // Full blocks acceptance even when a pop happens in the same cycle.
  // The reset term keeps handshakes quiet while reset is held, since these
  // paths are combinational from the request inputs.
  assign bus.memreq_val = any_val & ~q_full & ~reset;
  assign bus.memreq_msg = gnt_msg;
  assign fire           = bus.memreq_val & bus.memreq_rdy;

  assign bus.req0_rdy   = fire & (grant_id == ARB_PORT_IMEM);
  assign bus.req1_rdy   = fire & (grant_id == ARB_PORT_DMEM);

  // prio moves only on an accepted request, so a stalled grant holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio <= ARB_PORT_DMEM;
    else if (fire)
      prio <= ~grant_id;
  end

  riscv_mem_arbiter_idq #(
    .p_depth (p_max_out)
  ) u_idq (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Response steering: broadcast the payload, qualify valid by queue head.
  assign pop           = bus.memresp_val & ~q_empty;
  assign resp_msg      = bus.memresp_msg;
  assign bus.resp0_msg = resp_msg;
  assign bus.resp1_msg = resp_msg;
  assign bus.resp0_val = pop & (head_id == ARB_PORT_IMEM);
  assign bus.resp1_val = pop & (head_id == ARB_PORT_DMEM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (bus.memresp_val && q_empty)
      err <= 1'b1;
  end

`ifdef RISCV_MEM_ARB_STATS_EN
  logic [31:0] num_grant0;
  logic [31:0] num_grant1;
  logic [31:0] num_conflict;
  logic [31:0] num_full_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_grant0     <= '0;
      num_grant1     <= '0;
      num_conflict   <= '0;
      num_full_stall <= '0;
    end else begin
      if (fire && grant_id == ARB_PORT_IMEM) num_grant0 <= num_grant0 + 32'd1;
      if (fire && grant_id == ARB_PORT_DMEM) num_grant1 <= num_grant1 + 32'd1;
      if (both_val && !q_full)               num_conflict <= num_conflict + 32'd1;
      if (any_val && q_full)                 num_full_stall <= num_full_stall + 32'd1;
    end
  end
`endif

endmodule
